// File: rtl/button_debounce_sync.sv
// Push-button front end: per-bit synchroniser, shared sample-tick
// prescaler, per-button stability counter, level and edge pulses.
module button_debounce_sync #(
  parameter int NUM_BTN      = 3,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               btn_any,
  output logic               tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [NUM_BTN-1:0] sync_ff [SYNC_STAGES];
  logic [NUM_BTN-1:0] sync;
  logic [DW-1:0]      div_q;
  logic [DW-1:0]      div_nxt;
  logic [CW-1:0]      cnt_q [NUM_BTN];
  logic [CW-1:0]      cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] flip;
  logic [NUM_BTN-1:0] level_d;

  assign sync = sync_ff[SYNC_STAGES-1];

  // Plain flop chain bringing the raw pins into clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_ff[s] <= '0;
    end else begin
      sync_ff[0] <= btn_raw;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_ff[s] <= sync_ff[s-1];
    end
  end

  // Next prescaler value, wrapping at TICK_DIV-1
  always_comb begin
    div_nxt = div_q + DW'(1);
    if (div_q == DIV_LAST)
      div_nxt = '0;
  end

  // Prescaler register; tick is high while the counter sits at its last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      tick  <= 1'b0;
    end else begin
      div_q <= div_nxt;
      tick  <= (div_nxt == DIV_LAST);
    end
  end

  // Stability counting: agreement clears, disagreement counts ticks until a flip
  always_comb begin
    flip = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync[i] == btn_level[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          flip[i]  = 1'b1;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    level_d = btn_level ^ flip;
  end

  // Counters, debounced level, edge pulses and the any-pressed flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++)
        cnt_q[i] <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_any     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++)
        cnt_q[i] <= cnt_d[i];
      btn_level   <= level_d;
      btn_press   <= flip & ~btn_level;
      btn_release <= flip & btn_level;
      btn_any     <= |level_d;
    end
  end

endmodule

// File: tb/tb_button_debounce_sync.sv
// Directed bench for button_debounce_sync with a short tick period
// and stability count so debounce intervals stay a few cycles long.
module tb_button_debounce_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic [2:0] btn_release;
  logic       btn_any;
  logic       tick;

  int checks = 0;
  int errors = 0;

  button_debounce_sync #(
    .NUM_BTN(3),
    .TICK_DIV(4),
    .STABLE_TICKS(3),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_any(btn_any),
    .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] raw;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Apply raw, then watch 20 edges for the single level change and its pulses
  task automatic run_vec(input vec_t v, input string nm);
    logic [2:0] prev;
    int lat;
    int npulse;
    prev   = btn_level;
    lat    = -1;
    npulse = 0;
    btn_raw = v.raw;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if ((|btn_press) || (|btn_release))
        npulse++;
      if (lat < 0 && btn_level != prev) begin
        lat = n;
        chk({nm, " level"}, btn_level, v.lvl);
        chk({nm, " press"}, btn_press, v.prs);
        chk({nm, " release"}, btn_release, v.rel);
        chk({nm, " any"}, btn_any, |v.lvl);
      end
    end
    chk_rng({nm, " latency"}, lat, 11, 14);
    chk({nm, " pulse cycles"}, npulse, 1);
    chk({nm, " final level"}, btn_level, v.lvl);
  endtask

  initial begin
    int lat;
    int npress;
    int nchg;
    int nt;
    logic prev_tick;

    tbl[0] = '{raw: 3'b001, lvl: 3'b001, prs: 3'b001, rel: 3'b000};
    tbl[1] = '{raw: 3'b101, lvl: 3'b101, prs: 3'b100, rel: 3'b000};
    tbl[2] = '{raw: 3'b100, lvl: 3'b100, prs: 3'b000, rel: 3'b001};
    tbl[3] = '{raw: 3'b000, lvl: 3'b000, prs: 3'b000, rel: 3'b100};
    tbl[4] = '{raw: 3'b110, lvl: 3'b110, prs: 3'b110, rel: 3'b000};
    tbl[5] = '{raw: 3'b000, lvl: 3'b000, prs: 3'b000, rel: 3'b110};

    rst = 1'b1;
    btn_raw = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset level", btn_level, 0);
    chk("reset press", btn_press, 0);
    chk("reset release", btn_release, 0);
    chk("reset any", btn_any, 0);
    chk("reset tick", tick, 0);

    // tick expected on the 3rd, 7th, 11th ... edge after deassert
    rst = 1'b0;
    prev_tick = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      chk($sformatf("tick edge %0d", n), tick, ((n % 4) == 3) ? 1 : 0);
      chk($sformatf("tick pair %0d", n), (tick && prev_tick) ? 1 : 0, 0);
      prev_tick = tick;
    end

    for (int k = 0; k < 6; k++)
      run_vec(tbl[k], $sformatf("vec%0d", k));

    // Bounce on btn1: ten 3-cycle toggles never reach three ticks
    npress = 0;
    nchg = 0;
    for (int t = 0; t < 10; t++) begin
      btn_raw[1] = ~btn_raw[1];
      repeat (3) begin
        @(posedge clk); #1;
        if (btn_level != 3'b000) nchg++;
        if ((|btn_press) || (|btn_release)) npress++;
      end
    end
    chk("bounce level changes", nchg, 0);
    chk("bounce pulses", npress, 0);
    btn_raw[1] = 1'b1;
    lat = -1;
    npress = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (btn_press[1]) npress++;
      if (lat < 0 && btn_level[1]) lat = n;
    end
    chk_rng("bounce latency", lat, 11, 14);
    chk("bounce press count", npress, 1);
    chk("bounce level", btn_level, 3'b010);

    run_vec('{raw: 3'b100, lvl: 3'b100, prs: 3'b100, rel: 3'b010}, "swap");

    // Reset while btn0 is mid-count and btn2 is held
    btn_raw = 3'b101;
    nt = 0;
    for (int n = 0; n < 20 && nt < 2; n++) begin
      @(posedge clk); #1;
      if (tick) nt++;
    end
    chk("midreset ticks seen", nt, 2);
    chk("midreset pre level", btn_level, 3'b100);
    rst = 1'b1;
    #1;
    chk("midreset level", btn_level, 0);
    chk("midreset press", btn_press, 0);
    chk("midreset release", btn_release, 0);
    chk("midreset any", btn_any, 0);
    chk("midreset tick", tick, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("midreset held release", btn_release, 0);
    rst = 1'b0;
    lat = -1;
    npress = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (|btn_release) npress = npress + 100;
      if (btn_press != 3'b000) begin
        npress++;
        if (lat < 0) begin
          lat = n;
          chk("postreset press", btn_press, 3'b101);
        end
      end
    end
    chk_rng("postreset latency", lat, 11, 14);
    chk("postreset pulse count", npress, 1);
    chk("postreset level", btn_level, 3'b101);
    chk("postreset any", btn_any, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
